// File: rtl/lab3_pkg.sv
// Shared types and constants for the Lab3 z-stream deserializer.
package lab3_pkg;

    // Output-port holding state: EMPTY has no unconsumed word, FULL holds one.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    localparam int LAB3_WIDTH_DEFAULT = 8;

endpackage : lab3_pkg

// File: rtl/lab3_popcount.sv
// Combinational ones counter: WIDTH-bit input to CW-bit population count.
module lab3_popcount #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] bits,
    output logic [CW-1:0]    count
);

    // Sum every bit; CW is wide enough to hold WIDTH without truncation.
    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule : lab3_popcount

// File: rtl/lab3_z_deserializer.sv
// Deserializer for the Lab3 Mealy detector's serial z output.
// Collects WIDTH bits MSB-first and offers each word on a valid/ready port
// together with its ones count. A sticky overflow flag records dropped words.
// Optional feature: define LAB3_DESER_PARITY_EN to add the word_parity output.
//
// Output FSM:
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   OUT_EMPTY | no unconsumed word; word_valid low, word_ready ignored
//   OUT_FULL  | word_out holds a word awaiting word_ready
module lab3_z_deserializer
    import lab3_pkg::*;
#(
    parameter int WIDTH = LAB3_WIDTH_DEFAULT,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             z_in,
    input  logic             z_valid,
    input  logic             clear,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [CW-1:0]    ones_count,
`ifdef LAB3_DESER_PARITY_EN
    output logic             word_parity,
`endif
    output logic             overflow
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] BCNT_LAST = BW'(WIDTH - 1);

    // Only WIDTH-1 history bits are ever observable: the oldest bit of a
    // full WIDTH-bit shift register would be shifted out on the completing
    // edge, so it is not stored.
    logic [WIDTH-2:0] shreg;
    logic [BW-1:0]    bcnt;
    logic [WIDTH-1:0] new_word;
    logic [CW-1:0]    new_count;
    logic             word_done;
    out_state_t       state;

    assign new_word   = {shreg, z_in};
    assign word_done  = z_valid && !clear && (bcnt == BCNT_LAST);
    assign word_valid = (state == OUT_FULL);

    lab3_popcount #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_popcount (
        .bits  (new_word),
        .count (new_count)
    );

    // Collector: shift in one bit per qualified clock, wrap the bit counter
    // after the WIDTH-th bit. clear discards any partial word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
            bcnt  <= '0;
        end else if (clear) begin
            shreg <= '0;
            bcnt  <= '0;
        end else if (z_valid) begin
            shreg <= new_word[WIDTH-2:0];
            bcnt  <= (bcnt == BCNT_LAST) ? '0 : bcnt + BW'(1);
        end
    end

    // Output FSM with registered word, count, parity and sticky overflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= OUT_EMPTY;
            word_out    <= '0;
            ones_count  <= '0;
            overflow    <= 1'b0;
`ifdef LAB3_DESER_PARITY_EN
            word_parity <= 1'b0;
`endif
        end else if (clear) begin
            // The held word stays visible on word_out but is no longer valid.
            state    <= OUT_EMPTY;
            overflow <= 1'b0;
        end else begin
            case (state)
                OUT_EMPTY: begin
                    if (word_done) begin
                        word_out    <= new_word;
                        ones_count  <= new_count;
`ifdef LAB3_DESER_PARITY_EN
                        word_parity <= ^new_word;
`endif
                        state       <= OUT_FULL;
                    end
                end
                OUT_FULL: begin
                    if (word_ready) begin
                        if (word_done) begin
                            // Back-to-back: consume and reload in one edge.
                            word_out    <= new_word;
                            ones_count  <= new_count;
`ifdef LAB3_DESER_PARITY_EN
                            word_parity <= ^new_word;
`endif
                        end else begin
                            state <= OUT_EMPTY;
                        end
                    end else if (word_done) begin
                        // Consumer stalled too long: keep the held word.
                        overflow <= 1'b1;
                    end
                end
                default: state <= OUT_EMPTY;
            endcase
        end
    end

endmodule : lab3_z_deserializer
